// File: rtl/mt_pc_pkg.sv
// Shared constants, history-entry type and reset-vector helper for mt_pc_sched.
// hist_entry_t fields are sized for the widest supported config; users slice down.
package mt_pc_pkg;
    localparam int INSTR_BYTES = 4;
    localparam int HIST_TID_W  = 16;
    localparam int HIST_PC_W   = 64;

    typedef struct packed {
        logic                  valid;
        logic [HIST_TID_W-1:0] tid;
        logic [HIST_PC_W-1:0]  pc;
    } hist_entry_t;

    function automatic logic [HIST_PC_W-1:0] reset_vector(
        input logic [HIST_PC_W-1:0] base,
        input logic [HIST_PC_W-1:0] stride,
        input int unsigned          idx
    );
        return base + stride * HIST_PC_W'(idx);
    endfunction
endpackage

// File: rtl/mt_pc_hist.sv
// Issue-history buffer kept compacted with slot 0 oldest; push, tid-invalidate, flush.
// Latency: changes visible one cycle after the edge. Backpressure: none, push when full drops oldest.
module mt_pc_hist
    import mt_pc_pkg::*;
#(
    parameter int HIST_DEPTH = 4,
    parameter int CNT_W      = $clog2(HIST_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_vld,
    input  hist_entry_t           push_dat,
    input  logic                  inv_vld,
    input  logic [HIST_TID_W-1:0] inv_tid,
    input  logic                  flush,
    output hist_entry_t           ent [HIST_DEPTH],
    output logic [CNT_W-1:0]      count
);
    hist_entry_t      ent_q [HIST_DEPTH];
    hist_entry_t      ent_d [HIST_DEPTH];
    hist_entry_t      kept  [HIST_DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d, n;

    always_comb begin
        kept = '{default: '0};
        n    = '0;
        // Squeeze out invalidated entries so valid ones stay contiguous from slot 0.
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (ent_q[i].valid && !(inv_vld && ent_q[i].tid == inv_tid)) begin
                for (int j = 0; j < HIST_DEPTH; j++)
                    if (CNT_W'(j) == n) kept[j] = ent_q[i];
                n = n + CNT_W'(1);
            end
        end
        ent_d = kept;
        cnt_d = n;
        if (push_vld && !(inv_vld && push_dat.tid == inv_tid)) begin
            if (n == CNT_W'(HIST_DEPTH)) begin
                for (int j = 0; j < HIST_DEPTH - 1; j++) ent_d[j] = kept[j+1];
                ent_d[HIST_DEPTH-1] = push_dat;
            end else begin
                for (int j = 0; j < HIST_DEPTH; j++)
                    if (CNT_W'(j) == n) ent_d[j] = push_dat;
                cnt_d = n + CNT_W'(1);
            end
        end
        if (flush) begin
            ent_d = '{default: '0};
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign ent   = ent_q;
    assign count = cnt_q;
endmodule

// File: rtl/mt_pc_sched.sv
// Round-robin multithreaded PC scheduler with redirect; rollback history under MT_PC_ROLLBACK_EN.
// Latency: combinational issue select, PC updates visible the cycle after the edge. Backpressure: fetch_ready low freezes all state.
module mt_pc_sched
    import mt_pc_pkg::*;
#(
    parameter int                       NUM_THREADS     = 4,
    parameter int                       NUM_THREAD_GRPS = 2,
    parameter int                       ADDRESS_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_BASE      = 32'h0000_1000,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_STRIDE    = 32'h0000_0100,
    parameter int                       HIST_DEPTH      = 4,
    localparam int                      NT              = NUM_THREADS * NUM_THREAD_GRPS,
    localparam int                      BITS_TID        = $clog2(NT),
    localparam int                      CNT_W           = $clog2(HIST_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NT-1:0]            thread_en,
    input  logic                     fetch_ready,
    output logic                     issue_valid,
    output logic [BITS_TID-1:0]      issue_tid,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4,
    input  logic                     pc_src_e,
    input  logic [BITS_TID-1:0]      branch_tid_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    input  logic                     rollback_valid,
    output logic [CNT_W-1:0]         hist_count
);
    logic [ADDRESS_WIDTH-1:0] pc_q [NT];
    logic [ADDRESS_WIDTH-1:0] pc_d [NT];
    logic [BITS_TID-1:0]      rr_q, rr_d, sel;
    logic                     found, rb_act, hs;

    always_comb begin
        sel   = rr_q;
        found = 1'b0;
        for (int k = 0; k < NT; k++) begin
            if (!found && thread_en[rr_q + BITS_TID'(k)]) begin
                sel   = rr_q + BITS_TID'(k);
                found = 1'b1;
            end
        end
    end

    assign issue_tid   = sel;
    assign issue_valid = (|thread_en) & ~rb_act;
    assign pc          = pc_q[sel];
    assign pc_plus4    = pc + ADDRESS_WIDTH'(INSTR_BYTES);
    assign hs          = issue_valid & fetch_ready;

`ifdef MT_PC_ROLLBACK_EN
    hist_entry_t hist_ent [HIST_DEPTH];
    hist_entry_t push_ent;
    logic        rb_any;

    always_comb begin
        push_ent       = '0;
        push_ent.valid = 1'b1;
        push_ent.tid   = HIST_TID_W'(sel);
        push_ent.pc    = HIST_PC_W'(pc);
    end

    mt_pc_hist #(
        .HIST_DEPTH (HIST_DEPTH),
        .CNT_W      (CNT_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .push_vld (hs),
        .push_dat (push_ent),
        .inv_vld  (pc_src_e),
        .inv_tid  (HIST_TID_W'(branch_tid_e)),
        .flush    (rollback_valid),
        .ent      (hist_ent),
        .count    (hist_count)
    );

    assign rb_act = rollback_valid;
    assign rb_any = rollback_valid & hist_ent[0].valid;
`else
    logic rb_unused;
    assign rb_act     = 1'b0;
    assign rb_unused  = rollback_valid;
    assign hist_count = '0;
`endif

    always_comb begin
        for (int t = 0; t < NT; t++) pc_d[t] = pc_q[t];
        rr_d = rr_q;
        if (hs) begin
            pc_d[sel] = pc_plus4;
            rr_d      = sel + BITS_TID'(1);
        end
`ifdef MT_PC_ROLLBACK_EN
        // Walk newest to oldest so the oldest record of a thread lands last.
        if (rb_any) begin
            for (int i = HIST_DEPTH - 1; i >= 0; i--)
                for (int t = 0; t < NT; t++)
                    if (hist_ent[i].valid && hist_ent[i].tid == HIST_TID_W'(t))
                        pc_d[t] = ADDRESS_WIDTH'(hist_ent[i].pc);
            rr_d = BITS_TID'(hist_ent[0].tid);
        end
`endif
        if (pc_src_e) pc_d[branch_tid_e] = pc_target_e;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int t = 0; t < NT; t++)
                pc_q[t] <= ADDRESS_WIDTH'(reset_vector(HIST_PC_W'(RESET_BASE),
                                                       HIST_PC_W'(RESET_STRIDE), unsigned'(t)));
            rr_q <= '0;
        end else begin
            pc_q <= pc_d;
            rr_q <= rr_d;
        end
    end
endmodule

// File: tb/tb_mt_pc_sched.sv
// Scoreboard bench for mt_pc_sched (8 threads); expectations adapt to MT_PC_ROLLBACK_EN.
module tb_mt_pc_sched;
`ifdef MT_PC_ROLLBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  thread_en;
    logic        fetch_ready;
    logic        issue_valid;
    logic [2:0]  issue_tid;
    logic [31:0] pc, pc_plus4;
    logic        pc_src_e;
    logic [2:0]  branch_tid_e;
    logic [31:0] pc_target_e;
    logic        rollback_valid;
    logic [2:0]  hist_count;

    mt_pc_sched dut (
        .clk            (clk),
        .rst            (rst),
        .thread_en      (thread_en),
        .fetch_ready    (fetch_ready),
        .issue_valid    (issue_valid),
        .issue_tid      (issue_tid),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .pc_src_e       (pc_src_e),
        .branch_tid_e   (branch_tid_e),
        .pc_target_e    (pc_target_e),
        .rollback_valid (rollback_valid),
        .hist_count     (hist_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  tid;
        logic [31:0] pc;
    } iss_t;

    iss_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ev [8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_iss(input logic [2:0] tid, input logic [31:0] p);
        iss_t e;
        e.tid = tid;
        e.pc  = p;
        sb.push_back(e);
    endtask

    task automatic set_ev(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        ev[0] = a0; ev[1] = a1; ev[2] = a2; ev[3] = a3;
        ev[4] = a4; ev[5] = a5; ev[6] = a6; ev[7] = a7;
    endtask

    // Runs n cycles with fetch_ready high; every issue is matched against the scoreboard.
    task automatic run(input int n);
        iss_t e;
        for (int c = 0; c < n; c++) begin
            fetch_ready = 1'b1;
            #2;
            if (issue_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_issue", {61'd0, issue_tid}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("issue_tid", {61'd0, issue_tid}, {61'd0, e.tid});
                    chk("issue_pc", {32'd0, pc}, {32'd0, e.pc});
                    chk("pc_plus4", {32'd0, pc_plus4}, {32'd0, e.pc + 32'd4});
                end
            end
            @(posedge clk);
            #1;
        end
        fetch_ready = 1'b0;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // Reads every thread's PC through a one-hot enable without clocking any state change.
    task automatic peek();
        logic [7:0] en_save;
        en_save     = thread_en;
        fetch_ready = 1'b0;
        for (int t = 0; t < 8; t++) begin
            thread_en = 8'd1 << t;
            #1;
            chk($sformatf("pc_peek%0d", t), {32'd0, pc}, {32'd0, ev[t]});
        end
        thread_en = en_save;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        thread_en      = 8'hFF;
        fetch_ready    = 1'b1;
        pc_src_e       = 1'b1;
        branch_tid_e   = 3'd0;
        pc_target_e    = 32'hDEAD_0000;
        rollback_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b1;
        fetch_ready = 1'b0;
        pc_src_e    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        #2;
        chk("rst_issue_valid", {63'd0, issue_valid}, 64'd1);
        chk("rst_issue_tid", {61'd0, issue_tid}, 64'd0);
        chk("rst_pc", {32'd0, pc}, 64'h1000);
        chk("rst_pc_plus4", {32'd0, pc_plus4}, 64'h1004);
        chk("rst_hist_count", {61'd0, hist_count}, 64'd0);
        for (int t = 0; t < 8; t++) ev[t] = 32'h1000 + 32'h100 * t;
        peek();

        // Full round robin plus wrap
        thread_en = 8'hFF;
        for (int t = 0; t < 8; t++) expect_iss(3'(t), 32'h1000 + 32'h100 * t);
        expect_iss(3'd0, 32'h1004);
        run(9);
        chk("rr_hist_count", {61'd0, hist_count}, RB ? 64'd4 : 64'd0);

        // Sparse enable, then none enabled
        do_reset();
        thread_en = 8'b0010_0101;
        expect_iss(3'd0, 32'h1000);
        expect_iss(3'd2, 32'h1200);
        expect_iss(3'd5, 32'h1500);
        expect_iss(3'd0, 32'h1004);
        run(4);
        thread_en   = 8'h00;
        fetch_ready = 1'b1;
        #2;
        chk("none_en_valid", {63'd0, issue_valid}, 64'd0);
        @(posedge clk);
        #1;

        // fetch_ready low holds everything
        thread_en   = 8'hFF;
        fetch_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("stall_tid", {61'd0, issue_tid}, 64'd1);
            chk("stall_pc", {32'd0, pc}, 64'h1100);
            chk("stall_hist", {61'd0, hist_count}, RB ? 64'd4 : 64'd0);
            @(posedge clk);
            #1;
        end
        set_ev(32'h1008, 32'h1100, 32'h1204, 32'h1300, 32'h1400, 32'h1504, 32'h1600, 32'h1700);
        peek();
        expect_iss(3'd1, 32'h1100);
        run(1);

        // Redirect colliding with a handshake of the same thread
        do_reset();
        thread_en    = 8'b0000_1000;
        pc_src_e     = 1'b1;
        branch_tid_e = 3'd3;
        pc_target_e  = 32'h4000;
        expect_iss(3'd3, 32'h1300);
        run(1);
        pc_src_e = 1'b0;
        chk("redir_hist", {61'd0, hist_count}, 64'd0);
        expect_iss(3'd3, 32'h4000);
        run(1);
        chk("redir_hist_after", {61'd0, hist_count}, RB ? 64'd1 : 64'd0);

        // Rollback of four issues
        do_reset();
        thread_en = 8'hFF;
        for (int t = 0; t < 4; t++) expect_iss(3'(t), 32'h1000 + 32'h100 * t);
        run(4);
        rollback_valid = 1'b1;
        fetch_ready    = 1'b1;
        #2;
        chk("rb_issue_valid", {63'd0, issue_valid}, RB ? 64'd0 : 64'd1);
        if (!RB) expect_iss(3'd4, 32'h1400);
        run(1);
        rollback_valid = 1'b0;
        if (RB) set_ev(32'h1000, 32'h1100, 32'h1200, 32'h1300, 32'h1400, 32'h1500, 32'h1600, 32'h1700);
        else    set_ev(32'h1004, 32'h1104, 32'h1204, 32'h1304, 32'h1404, 32'h1500, 32'h1600, 32'h1700);
        peek();
        #2;
        chk("rb_next_tid", {61'd0, issue_tid}, RB ? 64'd0 : 64'd5);
        chk("rb_next_pc", {32'd0, pc}, RB ? 64'h1000 : 64'h1500);
        chk("rb_hist_count", {61'd0, hist_count}, 64'd0);
        @(posedge clk);
        #1;

        // Overflowed history with a repeated tid, then rollback on empty history
        do_reset();
        thread_en = 8'b0000_0100;
        expect_iss(3'd2, 32'h1200);
        expect_iss(3'd2, 32'h1204);
        expect_iss(3'd2, 32'h1208);
        run(3);
        thread_en = 8'hFF;
        expect_iss(3'd3, 32'h1300);
        expect_iss(3'd4, 32'h1400);
        run(2);
        chk("ovf_hist_count", {61'd0, hist_count}, RB ? 64'd4 : 64'd0);
        rollback_valid = 1'b1;
        if (!RB) expect_iss(3'd5, 32'h1500);
        run(1);
        rollback_valid = 1'b0;
        if (RB) set_ev(32'h1000, 32'h1100, 32'h1204, 32'h1300, 32'h1400, 32'h1500, 32'h1600, 32'h1700);
        else    set_ev(32'h1000, 32'h1100, 32'h120C, 32'h1304, 32'h1404, 32'h1504, 32'h1600, 32'h1700);
        peek();
        #2;
        chk("ovf_next_tid", {61'd0, issue_tid}, RB ? 64'd2 : 64'd6);
        chk("ovf_next_pc", {32'd0, pc}, RB ? 64'h1204 : 64'h1600);
        @(posedge clk);
        #1;
        rollback_valid = 1'b1;
        if (!RB) expect_iss(3'd6, 32'h1600);
        run(1);
        rollback_valid = 1'b0;
        #2;
        chk("empty_rb_tid", {61'd0, issue_tid}, RB ? 64'd2 : 64'd7);
        chk("empty_rb_pc", {32'd0, pc}, RB ? 64'h1204 : 64'h1700);
        chk("empty_rb_hist", {61'd0, hist_count}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mt_pc_sched.md
MT_PC_SCHED -- requirements
Module: mt_pc_sched

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4, threads per group (power of 2).
REQ-002 SHALL have parameter NUM_THREAD_GRPS, default 2, thread groups (power of 2); NT = NUM_THREADS*NUM_THREAD_GRPS, BITS_TID = $clog2(NT).
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32, PC width.
REQ-004 SHALL have parameter RESET_BASE, default 32'h0000_1000, start vector of thread 0.
REQ-005 SHALL have parameter RESET_STRIDE, default 32'h0000_0100, start-vector spacing per thread.
REQ-006 SHALL have parameter HIST_DEPTH, default 4, issue-history entries (>=2).
REQ-007 SHALL have port clk, input, 1, sole clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-009 SHALL have port thread_en, input, NT, per-thread issue enable; bit index = {tgrp,tid}.
REQ-010 SHALL have port fetch_ready, input, 1, fetch accepts issued PC.
REQ-011 SHALL have port issue_valid, output, 1, issue_tid/pc valid.
REQ-012 SHALL have port issue_tid, output, BITS_TID, selected thread {tgrp,tid}.
REQ-013 SHALL have port pc, output, ADDRESS_WIDTH, PC of issue_tid.
REQ-014 SHALL have port pc_plus4, output, ADDRESS_WIDTH, pc + 4.
REQ-015 SHALL have port pc_src_e, input, 1, EX redirect strobe.
REQ-016 SHALL have port branch_tid_e, input, BITS_TID, redirected thread.
REQ-017 SHALL have port pc_target_e, input, ADDRESS_WIDTH, redirect target.
REQ-018 SHALL have port rollback_valid, input, 1, restore PCs of recent issues.
REQ-019 SHALL have port hist_count, output, $clog2(HIST_DEPTH+1), valid history entries.

Function
REQ-020 SHALL hold one PC register per thread (NT total).
REQ-021 SHALL select issue_tid combinationally as the first thread with thread_en set, searching from rr_ptr upward, wrapping at NT.
REQ-022 SHALL drive issue_valid = |thread_en && !rollback_valid; pc = PC[issue_tid]; pc_plus4 wraps modulo 2^ADDRESS_WIDTH.
REQ-023 SHALL on handshake (issue_valid && fetch_ready) write PC[issue_tid] <= pc_plus4 and rr_ptr <= issue_tid+1 (mod NT), same edge.
REQ-024 SHALL hold all PCs and rr_ptr unchanged while fetch_ready is low; issue_tid/pc stable unless thread_en changes.
REQ-025 SHALL on pc_src_e write PC[branch_tid_e] <= pc_target_e; redirect overrides a same-cycle handshake increment or rollback restore of that thread.
REQ-026 SHALL on handshake push {issue_tid, pc} into history; when full, the oldest entry is dropped; hist_count saturates at HIST_DEPTH.
REQ-027 SHALL on pc_src_e invalidate all history entries with tid == branch_tid_e, including one pushed the same cycle.
REQ-028 SHALL on rollback_valid restore PC[tid] <= recorded pc for each valid entry; for repeated tids the oldest entry wins; then clear history and set rr_ptr to the oldest entry's tid.
REQ-029 SHALL treat rollback with empty history as no PC/rr_ptr change.
REQ-030 SHALL give single-cycle latency: an update at edge N is visible on pc after edge N.

Reset
REQ-031 SHALL on rst low at a clk edge set PC[i] = RESET_BASE + i*RESET_STRIDE, rr_ptr = 0, history empty, hist_count = 0; rst overrides all inputs.
REQ-032 SHALL after reset with thread_en all set show issue_tid = 0, pc = RESET_BASE, issue_valid = 1.

Configuration
REQ-033 SHALL compile rollback under macro MT_PC_ROLLBACK_EN: defined gives REQ-026..029; undefined gives no history storage, rollback_valid ignored (excluded from issue_valid), hist_count tied 0.

Structure
REQ-034 SHALL place INSTR_BYTES (4), the history-entry typedef {valid, tid, pc}, and the reset-vector function in package mt_pc_pkg.
REQ-035 SHALL implement the history as sub-module mt_pc_hist (shift buffer with push, tid-invalidate, flush, oldest-first read).

Verification (NUM_THREADS=4, NUM_THREAD_GRPS=2, defaults)
REQ-036 SHALL check reset: PCs 0x1000..0x1700, issue_tid 0, pc 0x1000, hist_count 0.
REQ-037 SHALL check all enabled, fetch_ready high 9 cycles -> tids 0..7 then 0, with pc 0x1004.
REQ-038 SHALL check thread_en=8'b0010_0101 -> tids 0,2,5,0; thread_en=0 -> issue_valid 0.
REQ-039 SHALL check handshake tid 3 with same-cycle pc_src_e tid 3, target 0x4000 -> next tid-3 issue pc 0x4000, no tid-3 history entry.
REQ-040 SHALL check issue tids 0..3, then rollback_valid -> PCs 0x1000/0x1100/0x1200/0x1300, next issue tid 0 pc 0x1000, hist_count 0.
REQ-041 SHALL check fetch_ready low 5 cycles -> issue_tid/pc stable, no PC change, hist_count unchanged.
